// File: rtl/obstacle_pkg.sv
// rtl/obstacle_pkg.sv - shared tile geometry constants and row-divider state encoding
package obstacle_pkg;

  localparam int OBSTACLE_WIDTH  = 10;
  localparam int OBSTACLE_HEIGHT = 20;
  localparam int H_RES_DEFAULT   = 640;
  localparam int TILE_COLS       = H_RES_DEFAULT / OBSTACLE_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV   = 2'd1,
    READY = 2'd2
  } div_state_t;

  function automatic int tile_cols(input int h_res, input int tile_w);
    return h_res / tile_w;
  endfunction

endpackage

// File: rtl/obstacle_row_divider.sv
// rtl/obstacle_row_divider.sv - per-frame camera_y / tile-height divider run during blanking
// Repeated subtraction: one tile height per cycle, restartable by any frame_start.
module obstacle_row_divider import obstacle_pkg::*; #(
  parameter int HEIGHT    = OBSTACLE_HEIGHT,
  parameter int PHY_WIDTH = 14,
  parameter int REM_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_start,
  input  logic [PHY_WIDTH-1:0] camera_y,
  output logic [REM_WIDTH-1:0] rem_out,
  output logic [PHY_WIDTH-1:0] quot,
  output logic                 map_ready
);

  localparam logic [PHY_WIDTH-1:0] H = PHY_WIDTH'(HEIGHT);

  div_state_t           state;
  logic [PHY_WIDTH-1:0] rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rem       <= '0;
      quot      <= '0;
      map_ready <= 1'b0;
    end else if (frame_start) begin
      state     <= DIV;
      rem       <= camera_y;
      quot      <= '0;
      map_ready <= 1'b0;
    end else begin
      case (state)
        DIV: begin
          if (rem >= H) begin
            rem  <= rem - H;
            quot <= quot + 1'b1;
          end else begin
            state     <= READY;
            map_ready <= 1'b1;
          end
        end
        default: state <= state;
      endcase
    end
  end

  // The remainder is always below HEIGHT once READY, so it fits the in-tile index width.
  assign rem_out = rem[REM_WIDTH-1:0];

endmodule

// File: rtl/obstacle_tile_locator.sv
// rtl/obstacle_tile_locator.sv - raster position to obstacle tile coordinates and hit flag
// Optional platform tiles are built when OBSTACLE_PLATFORM_EN is defined.
module obstacle_tile_locator #(
  parameter int OBSTACLE_WIDTH  = obstacle_pkg::OBSTACLE_WIDTH,
  parameter int OBSTACLE_HEIGHT = obstacle_pkg::OBSTACLE_HEIGHT,
  parameter int SCREEN_WIDTH    = 10,
  parameter int PHY_WIDTH       = 14,
  parameter int H_RES           = 640,
  parameter int WALL_COLS       = 2,
  parameter int PLATFORM_PERIOD = 8,
  parameter int PLATFORM_LEN    = 8
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic                    frame_start,
  input  logic [PHY_WIDTH-1:0]    camera_y,
  input  logic [SCREEN_WIDTH-1:0] pixel_x,
  input  logic [SCREEN_WIDTH-1:0] pixel_y,
  input  logic                    video_on,
  output logic [SCREEN_WIDTH-1:0] obstacle_x_rom,
  output logic [SCREEN_WIDTH-1:0] obstacle_y_rom,
  output logic [PHY_WIDTH-1:0]    obstacle_abs_pos_x,
  output logic [PHY_WIDTH-1:0]    obstacle_abs_pos_y,
  output logic                    obstacle_on,
  output logic                    map_ready
);

  import obstacle_pkg::*;

  localparam int                      COLS    = tile_cols(H_RES, OBSTACLE_WIDTH);
  localparam logic [PHY_WIDTH-1:0]    WALL_LO = PHY_WIDTH'(WALL_COLS);
  localparam logic [PHY_WIDTH-1:0]    WALL_HI = PHY_WIDTH'(COLS - WALL_COLS);
  localparam logic [SCREEN_WIDTH-1:0] X_LAST  = SCREEN_WIDTH'(OBSTACLE_WIDTH - 1);
  localparam logic [SCREEN_WIDTH-1:0] Y_LAST  = SCREEN_WIDTH'(OBSTACLE_HEIGHT - 1);

  logic [SCREEN_WIDTH-1:0] div_rem;
  logic [PHY_WIDTH-1:0]    div_quot;
  logic                    div_ready;

  obstacle_row_divider #(
    .HEIGHT    (OBSTACLE_HEIGHT),
    .PHY_WIDTH (PHY_WIDTH),
    .REM_WIDTH (SCREEN_WIDTH)
  ) u_row_divider (
    .clk         (sys_clk),
    .rst_n       (sys_rst_n),
    .frame_start (frame_start),
    .camera_y    (camera_y),
    .rem_out     (div_rem),
    .quot        (div_quot),
    .map_ready   (div_ready)
  );

  assign map_ready = div_ready;

  // Stage 1: incremental tile counters, valid for the pixel just presented.
  logic [SCREEN_WIDTH-1:0] x_rom, y_rom;
  logic [PHY_WIDTH-1:0]    col, row;
  logic                    vis_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      x_rom <= '0;
      y_rom <= '0;
      col   <= '0;
      row   <= '0;
      vis_q <= 1'b0;
    end else begin
      vis_q <= video_on;
      if (video_on) begin
        if (pixel_x == '0) begin
          x_rom <= '0;
          col   <= '0;
          if (pixel_y == '0) begin
            y_rom <= div_rem;
            row   <= div_quot;
          end else if (y_rom == Y_LAST) begin
            y_rom <= '0;
            row   <= row + 1'b1;
          end else begin
            y_rom <= y_rom + 1'b1;
          end
        end else if (x_rom == X_LAST) begin
          x_rom <= '0;
          col   <= col + 1'b1;
        end else begin
          x_rom <= x_rom + 1'b1;
        end
      end
    end
  end

  logic wall, platform;

  always_comb begin
    wall = (col < WALL_LO) || (col >= WALL_HI);
  end

`ifdef OBSTACLE_PLATFORM_EN
  localparam int                   PLAT_SHIFT = $clog2(PLATFORM_PERIOD);
  localparam logic [PHY_WIDTH-1:0] PLAT_MASK  = PHY_WIDTH'(PLATFORM_PERIOD - 1);
  localparam logic [PHY_WIDTH-1:0] PLAT_LEN   = PHY_WIDTH'(PLATFORM_LEN);

  logic [PHY_WIDTH-1:0] plat_rel, plat_start;

  // Platforms step 4 tiles right every platform row, repeating after 8 platforms.
  always_comb begin
    plat_rel   = col - WALL_LO;
    plat_start = PHY_WIDTH'({row[PLAT_SHIFT +: 3], 2'b00});
    platform   = ((row & PLAT_MASK) == '0) &&
                 (plat_rel >= plat_start) &&
                 (plat_rel < plat_start + PLAT_LEN);
  end
`else
  always_comb begin
    platform = 1'b0;
  end
`endif

  // Stage 2: hit test and registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      obstacle_x_rom     <= '0;
      obstacle_y_rom     <= '0;
      obstacle_abs_pos_x <= '0;
      obstacle_abs_pos_y <= '0;
      obstacle_on        <= 1'b0;
    end else begin
      obstacle_x_rom     <= x_rom;
      obstacle_y_rom     <= y_rom;
      obstacle_abs_pos_x <= col;
      obstacle_abs_pos_y <= row;
      obstacle_on        <= vis_q && div_ready && (wall || platform);
    end
  end

endmodule

// File: tb/tb_obstacle_tile_locator.sv
// tb/tb_obstacle_tile_locator.sv - directed self-checking bench for obstacle_tile_locator
module tb_obstacle_tile_locator;

  localparam int SW = 10;
  localparam int PW = 14;

`ifdef OBSTACLE_PLATFORM_EN
  localparam logic PLAT = 1'b1;
`else
  localparam logic PLAT = 1'b0;
`endif

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          frame_start = 1'b0;
  logic          video_on = 1'b0;
  logic [PW-1:0] camera_y = '0;
  logic [SW-1:0] pixel_x = '0;
  logic [SW-1:0] pixel_y = '0;
  logic [SW-1:0] obstacle_x_rom, obstacle_y_rom;
  logic [PW-1:0] obstacle_abs_pos_x, obstacle_abs_pos_y;
  logic          obstacle_on, map_ready;

  int n_vec = 0;
  int n_err = 0;

  always #5 sys_clk = ~sys_clk;

  obstacle_tile_locator dut (
    .sys_clk            (sys_clk),
    .sys_rst_n          (sys_rst_n),
    .frame_start        (frame_start),
    .camera_y           (camera_y),
    .pixel_x            (pixel_x),
    .pixel_y            (pixel_y),
    .video_on           (video_on),
    .obstacle_x_rom     (obstacle_x_rom),
    .obstacle_y_rom     (obstacle_y_rom),
    .obstacle_abs_pos_x (obstacle_abs_pos_x),
    .obstacle_abs_pos_y (obstacle_abs_pos_y),
    .obstacle_on        (obstacle_on),
    .map_ready          (map_ready)
  );

  task automatic step(input int x, input int y, input logic v);
    pixel_x  = SW'(x);
    pixel_y  = SW'(y);
    video_on = v;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic start_frame(input int cam);
    camera_y    = PW'(cam);
    frame_start = 1'b1;
    @(posedge sys_clk);
    #1;
    frame_start = 1'b0;
  endtask

  task automatic wait_ready(input int limit, output int cycles);
    cycles = 0;
    while (!map_ready && cycles < limit) begin
      @(posedge sys_clk);
      #1;
      cycles++;
    end
    if (!map_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_ready: map_ready=%0b after %0d cycles, required 1", map_ready, cycles);
    end
  endtask

  task automatic test_reset;
    sys_rst_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    n_vec++;
    if ({obstacle_x_rom, obstacle_y_rom, obstacle_abs_pos_x, obstacle_abs_pos_y,
         obstacle_on, map_ready} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: x_rom=%0d y_rom=%0d abs_x=%0d abs_y=%0d on=%0b ready=%0b, required all 0",
               obstacle_x_rom, obstacle_y_rom, obstacle_abs_pos_x, obstacle_abs_pos_y, obstacle_on, map_ready);
    end
    sys_rst_n = 1'b1;
    for (int x = 0; x < 5; x++) begin
      step(x, 0, 1'b1);
      if (x > 0) begin
        n_vec++;
        if (obstacle_on !== 1'b0) begin
          n_err++;
          $display("FAIL reset_no_frame_on px=%0d: on=%0b, required 0", x - 1, obstacle_on);
        end
      end
    end
    step(5, 0, 1'b0);
  endtask

  task automatic test_camera45;
    int cyc;
    step(0, 0, 1'b0);
    start_frame(45);
    n_vec++;
    if (map_ready !== 1'b0) begin
      n_err++;
      $display("FAIL cam45_ready_low: map_ready=%0b, required 0", map_ready);
    end
    wait_ready(50, cyc);
    n_vec++;
    if (cyc !== 3) begin
      n_err++;
      $display("FAIL cam45_div_cycles: got %0d, required 3", cyc);
    end
    for (int x = 0; x <= 640; x++) begin
      step((x < 640) ? x : 639, 0, x < 640);
      if (x == 1) begin
        n_vec++;
        if (obstacle_abs_pos_y !== 14'd2 || obstacle_y_rom !== 10'd5 || obstacle_x_rom !== 10'd0 ||
            obstacle_abs_pos_x !== 14'd0 || obstacle_on !== 1'b1) begin
          n_err++;
          $display("FAIL cam45_px0: abs_y=%0d y_rom=%0d x_rom=%0d abs_x=%0d on=%0b, required 2 5 0 0 1",
                   obstacle_abs_pos_y, obstacle_y_rom, obstacle_x_rom, obstacle_abs_pos_x, obstacle_on);
        end
      end
      if (x == 26) begin
        n_vec++;
        if (obstacle_abs_pos_x !== 14'd2 || obstacle_x_rom !== 10'd5 || obstacle_on !== 1'b0) begin
          n_err++;
          $display("FAIL cam45_px25: abs_x=%0d x_rom=%0d on=%0b, required 2 5 0",
                   obstacle_abs_pos_x, obstacle_x_rom, obstacle_on);
        end
      end
      if (x >= 621) begin
        n_vec++;
        if (obstacle_abs_pos_x !== PW'((x - 1) / 10) || obstacle_x_rom !== SW'((x - 1) % 10) ||
            obstacle_on !== 1'b1 || obstacle_abs_pos_y !== 14'd2) begin
          n_err++;
          $display("FAIL right_wall px=%0d: abs_x=%0d x_rom=%0d on=%0b abs_y=%0d, required %0d %0d 1 2",
                   x - 1, obstacle_abs_pos_x, obstacle_x_rom, obstacle_on, obstacle_abs_pos_y,
                   (x - 1) / 10, (x - 1) % 10);
        end
      end
    end
  endtask

  task automatic test_row_wrap;
    for (int y = 1; y <= 15; y++) begin
      step(0, y, 1'b1);
      step(1, y, 1'b0);
      if (y >= 14) begin
        n_vec++;
        if (obstacle_y_rom !== SW'((5 + y) % 20) || obstacle_abs_pos_y !== PW'(2 + (5 + y) / 20) ||
            obstacle_on !== 1'b1) begin
          n_err++;
          $display("FAIL row_wrap line=%0d: y_rom=%0d abs_y=%0d on=%0b, required %0d %0d 1",
                   y, obstacle_y_rom, obstacle_abs_pos_y, obstacle_on, (5 + y) % 20, 2 + (5 + y) / 20);
        end
      end
    end
    // video_on low: the stage-2 flag must drop even though counters hold.
    step(1, 15, 1'b0);
    n_vec++;
    if (obstacle_on !== 1'b0 || obstacle_y_rom !== 10'd0) begin
      n_err++;
      $display("FAIL blank_hold: on=%0b y_rom=%0d, required 0 0", obstacle_on, obstacle_y_rom);
    end
  endtask

  task automatic test_platform;
    int cyc;
    step(0, 0, 1'b0);
    start_frame(160);
    wait_ready(50, cyc);
    n_vec++;
    if (cyc !== 9) begin
      n_err++;
      $display("FAIL plat_div_cycles: got %0d, required 9", cyc);
    end
    for (int x = 0; x <= 141; x++) begin
      step(x, 0, 1'b1);
      if (x == 61) begin
        n_vec++;
        if (obstacle_abs_pos_x !== 14'd6 || obstacle_abs_pos_y !== 14'd8 || obstacle_on !== PLAT) begin
          n_err++;
          $display("FAIL plat_col6: abs_x=%0d abs_y=%0d on=%0b, required 6 8 %0b",
                   obstacle_abs_pos_x, obstacle_abs_pos_y, obstacle_on, PLAT);
        end
      end
      if (x == 141) begin
        n_vec++;
        if (obstacle_abs_pos_x !== 14'd14 || obstacle_on !== 1'b0) begin
          n_err++;
          $display("FAIL plat_col14: abs_x=%0d on=%0b, required 14 0", obstacle_abs_pos_x, obstacle_on);
        end
      end
    end
    step(0, 0, 1'b0);
  endtask

  task automatic test_restart;
    int cyc;
    start_frame(10000);
    repeat (100) @(posedge sys_clk);
    #1;
    n_vec++;
    if (map_ready !== 1'b0) begin
      n_err++;
      $display("FAIL restart_mid_div: map_ready=%0b, required 0", map_ready);
    end
    start_frame(16383);
    wait_ready(1000, cyc);
    n_vec++;
    if (cyc !== 820) begin
      n_err++;
      $display("FAIL restart_div_cycles: got %0d, required 820", cyc);
    end
    step(0, 0, 1'b1);
    step(1, 0, 1'b0);
    n_vec++;
    if (obstacle_abs_pos_y !== 14'd819 || obstacle_y_rom !== 10'd3 || obstacle_on !== 1'b1) begin
      n_err++;
      $display("FAIL restart_result: abs_y=%0d y_rom=%0d on=%0b, required 819 3 1",
               obstacle_abs_pos_y, obstacle_y_rom, obstacle_on);
    end
  endtask

  task automatic test_reset_mid_frame;
    int cyc;
    for (int x = 0; x < 30; x++) step(x, 0, 1'b1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    n_vec++;
    if ({obstacle_x_rom, obstacle_y_rom, obstacle_abs_pos_x, obstacle_abs_pos_y,
         obstacle_on, map_ready} !== '0) begin
      n_err++;
      $display("FAIL async_reset: x_rom=%0d y_rom=%0d abs_x=%0d abs_y=%0d on=%0b ready=%0b, required all 0",
               obstacle_x_rom, obstacle_y_rom, obstacle_abs_pos_x, obstacle_abs_pos_y, obstacle_on, map_ready);
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
    for (int x = 0; x < 5; x++) begin
      step(x, 0, 1'b1);
      if (x > 0) begin
        n_vec++;
        if (obstacle_on !== 1'b0 || map_ready !== 1'b0) begin
          n_err++;
          $display("FAIL post_reset px=%0d: on=%0b ready=%0b, required 0 0", x - 1, obstacle_on, map_ready);
        end
      end
    end
    step(5, 0, 1'b0);
    start_frame(45);
    wait_ready(50, cyc);
    step(0, 0, 1'b1);
    step(1, 0, 1'b0);
    n_vec++;
    if (obstacle_on !== 1'b1 || obstacle_abs_pos_y !== 14'd2 || obstacle_y_rom !== 10'd5) begin
      n_err++;
      $display("FAIL reset_recover: on=%0b abs_y=%0d y_rom=%0d, required 1 2 5",
               obstacle_on, obstacle_abs_pos_y, obstacle_y_rom);
    end
  endtask

  initial begin
    test_reset;
    test_camera45;
    test_row_wrap;
    test_platform;
    test_restart;
    test_reset_mid_frame;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
